// File: rtl/alu_result_display_pkg.sv
// Shared 7-segment display constants and hex glyph table, common to the
// ALU result, regfile and debug display blocks.
package alu_result_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} glyphs for 0..F
    function automatic logic [6:0] hex7(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0: pattern = 7'h40;
            4'h1: pattern = 7'h79;
            4'h2: pattern = 7'h24;
            4'h3: pattern = 7'h30;
            4'h4: pattern = 7'h19;
            4'h5: pattern = 7'h12;
            4'h6: pattern = 7'h02;
            4'h7: pattern = 7'h78;
            4'h8: pattern = 7'h00;
            4'h9: pattern = 7'h10;
            4'hA: pattern = 7'h08;
            4'hB: pattern = 7'h03;
            4'hC: pattern = 7'h46;
            4'hD: pattern = 7'h21;
            4'hE: pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/alu_result_display_hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment decoder.
module hex_to_seg7
    import alu_result_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex7(nibble);

endmodule

// File: rtl/alu_result_display.sv
// Captures the ALU result and overflow flag, then scans them out as hex
// digits on a multiplexed common-anode 7-segment display.
module alu_result_display
    import alu_result_display_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int DIGITS     = 8,
    parameter int LEAD_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  din_valid,
    input  logic                  ovf,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] shadow;
    logic                ovf_q;
    logic [CNT_W-1:0]    scan_cnt;
    logic [IDX_W-1:0]    digit_idx;

    logic [3:0]          nibble;
    logic [DIGITS-1:0]   an_next;
    logic                blank;
    logic [6:0]          hex_seg;

    // Walk from the most significant digit down so the running zero flag
    // covers nibbles i..DIGITS-1 when digit i is reached.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        nibble     = 4'h0;
        an_next    = '1;
        blank      = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (shadow[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == digit_idx) begin
                nibble     = shadow[4*i +: 4];
                an_next[i] = 1'b0;
                blank      = (LEAD_BLANK != 0) && (i != 0) && upper_zero;
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            ovf_q     <= 1'b0;
            scan_cnt  <= '0;
            digit_idx <= '0;
            an        <= AN_OFF[DIGITS-1:0];
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
        end else begin
            if (din_valid) begin
                shadow <= din;
                ovf_q  <= ovf;
            end
            if (scan_cnt == CNT_MAX) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            // Outputs follow the pre-edge digit/shadow, so a capture shows up one edge later
            an  <= an_next;
            seg <= blank ? SEG_BLANK : hex_seg;
            dp  <= !(ovf_q && (digit_idx == '0));
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Bench for alu_result_display: one blanking and one non-blanking instance
// share stimulus and are compared against a slot-timing model every cycle.
module tb_alu_result_display;

    localparam int SCAN_DIV = 4;
    localparam int DIGITS   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        ovf = 1'b0;

    logic [7:0]  an_b, an_n;
    logic [6:0]  seg_b, seg_n;
    logic        dp_b, dp_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_result_display #(.SCAN_DIV(SCAN_DIV), .DIGITS(DIGITS), .LEAD_BLANK(1)) dut_blank (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .ovf(ovf),
        .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    alu_result_display #(.SCAN_DIV(SCAN_DIV), .DIGITS(DIGITS), .LEAD_BLANK(0)) dut_noblank (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .ovf(ovf),
        .an(an_n), .seg(seg_n), .dp(dp_n)
    );

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [6:0] exp_seg(input logic [31:0] v, input int d, input bit lb);
        logic [31:0] upper;
        upper = v >> (4 * d);
        if (lb && d > 0 && upper == 32'h0) return 7'h7F;
        return hex_tab[upper[3:0]];
    endfunction

    // Model: the k-th edge after reset shows digit ((k-1)/SCAN_DIV) mod DIGITS
    // using the value captured before that edge.
    bit          m_valid = 1'b0;
    int          m_k;
    int          m_d;
    logic [31:0] m_shadow;
    logic        m_ovf;
    logic [7:0]  e_an;
    logic [6:0]  e_seg_b, e_seg_n;
    logic        e_dp;

    always @(posedge clk) begin
        if (rst) begin
            m_valid  = 1'b1;
            m_k      = 0;
            m_shadow = '0;
            m_ovf    = 1'b0;
            e_an     = 8'hFF;
            e_seg_b  = 7'h7F;
            e_seg_n  = 7'h7F;
            e_dp     = 1'b1;
        end else if (m_valid) begin
            m_k++;
            m_d     = ((m_k - 1) / SCAN_DIV) % DIGITS;
            e_an    = ~(8'd1 << m_d);
            e_seg_b = exp_seg(m_shadow, m_d, 1'b1);
            e_seg_n = exp_seg(m_shadow, m_d, 1'b0);
            e_dp    = !(m_ovf && m_d == 0);
            if (din_valid) begin
                m_shadow = din;
                m_ovf    = ovf;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            total++;
            if (an_b !== e_an || seg_b !== e_seg_b || dp_b !== e_dp ||
                an_n !== e_an || seg_n !== e_seg_n || dp_n !== e_dp) begin
                bad++;
                $display("FAIL model k=%0d an=%h/%h seg=%h/%h dp=%b/%b got, an=%h seg=%h/%h dp=%b required",
                         m_k, an_b, an_n, seg_b, seg_n, dp_b, dp_n, e_an, e_seg_b, e_seg_n, e_dp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    // Returns on the first cycle of a fresh slot whose anode pattern is target.
    task automatic wait_fresh(input logic [7:0] target);
        int n;
        n = 0;
        while (an_b == target && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (an_b != target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_an timeout got=%h required=%h", an_b, target);
        end
    endtask

    task automatic load(input logic [31:0] v, input logic o);
        din       = v;
        ovf       = o;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din       = '0;
        ovf       = 1'b0;
    endtask

    initial begin
        int          cyc;
        logic [7:0]  prev;

        // Reset hold and release
        repeat (3) begin
            @(negedge clk);
            chk("rst_an", an_b, 8'hFF);
            chk("rst_seg", seg_b, 7'h7F);
            chk("rst_dp", dp_b, 1'b1);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_an", an_b, 8'hFE);
        chk("first_seg", seg_b, 7'h40);
        chk("first_seg_nb", seg_n, 7'h40);

        // Load 0x81 and blanking
        load(32'h0000_0081, 1'b0);
        wait_fresh(8'hFD);
        chk("d1_seg", seg_b, 7'h00);
        wait_fresh(8'hFB);
        chk("d2_seg_blank", seg_b, 7'h7F);
        chk("d2_seg_noblank", seg_n, 7'h40);
        wait_fresh(8'h7F);
        chk("d7_seg_blank", seg_b, 7'h7F);
        chk("d7_seg_noblank", seg_n, 7'h40);
        wait_fresh(8'hFE);
        chk("d0_seg", seg_b, 7'h79);

        // Full value with overflow, scan period
        load(32'hFFFF_FFFF, 1'b1);
        wait_fresh(8'hFE);
        chk("ff_d0_seg", seg_b, 7'h0E);
        chk("ovf_d0_dp", dp_b, 1'b0);
        cyc  = 0;
        prev = an_b;
        do begin
            @(negedge clk);
            cyc++;
            if (an_b == 8'hFE && prev != 8'hFE) break;
            prev = an_b;
        end while (cyc < 100);
        chk("scan_period", cyc, 32);
        wait_fresh(8'hFD);
        chk("ovf_d1_dp", dp_b, 1'b1);
        chk("ff_d1_seg", seg_b, 7'h0E);

        // Overflow cleared by a later load
        load(32'hFFFF_FFFF, 1'b0);
        wait_fresh(8'hFE);
        chk("ovf_clear_dp", dp_b, 1'b1);

        // Capture on the same edge as the scan wrap
        wait_fresh(8'hFB);
        @(negedge clk);
        @(negedge clk);
        din       = 32'h1234_5678;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din       = '0;
        chk("wrap_old_an", an_b, 8'hFB);
        chk("wrap_old_seg", seg_b, 7'h0E);
        @(negedge clk);
        chk("wrap_new_an", an_b, 8'hF7);
        chk("wrap_new_seg", seg_b, 7'h12);
        repeat (3) begin
            @(negedge clk);
            chk("wrap_slot_seg", seg_b, 7'h12);
        end

        // Mid-scan reset on digit 5
        wait_fresh(8'hDF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_an", an_b, 8'hFF);
        chk("midrst_seg", seg_b, 7'h7F);
        @(negedge clk);
        chk("restart_an", an_b, 8'hFE);
        chk("restart_seg", seg_b, 7'h40);

        // Inputs ignored without din_valid
        load(32'h0000_00A5, 1'b0);
        repeat (40) begin
            din = $urandom;
            ovf = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        wait_fresh(8'hFE);
        chk("hold_d0_seg", seg_b, 7'h12);
        chk("hold_d0_dp", dp_b, 1'b1);
        wait_fresh(8'hFD);
        chk("hold_d1_seg", seg_b, 7'h08);
        wait_fresh(8'hFB);
        chk("hold_d2_seg_blank", seg_b, 7'h7F);
        chk("hold_d2_seg_noblank", seg_n, 7'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
